// File: rtl/mips_mc_control_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// There is no valid/ready handshake on this bundle: the controller is a
// Moore machine, every control output is a function of the current state
// (plus Op/Function/Zero where noted) and is consumed by the datapath on the
// next rising clock edge. Op/Function come from the IR, which stays stable
// from the end of FETCH until the next FETCH.
interface mips_mc_control_if;
  logic [5:0] Op;
  logic [5:0] Function;
  logic       Zero;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       PCSource;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic       PCSel;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUCtrl;
  logic [3:0] state;
  logic       done;
  logic       illegal;

  // Controller side: reads instruction fields and Zero, drives controls.
  modport master (
    input  Op, Function, Zero,
    output IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA,
           RegWrite, RegDst, PCSel, ALUSrcB, ALUCtrl, state, done, illegal
  );

  // Datapath side: supplies instruction fields and Zero, consumes controls.
  modport slave (
    output Op, Function, Zero,
    input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA,
           RegWrite, RegDst, PCSel, ALUSrcB, ALUCtrl, state, done, illegal
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM. Each instruction runs FETCH, DECODE, then
// one to three execute states, and returns to FETCH. Supports lw, sw, beq,
// addi and R-type add/sub/and/or/slt/nor; anything else pulses illegal in
// DECODE and goes straight back to FETCH without asserting any write enable.
module mips_mc_control (
  input logic                clk,
  input logic                reset,
  mips_mc_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_WB_MEM  = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_WB_R    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_WB_I    = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t state_q;
  state_t state_d;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b101010, 6'b100111: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      6'b100111: return ALU_NOR;
      default:   return ALU_ADD;
    endcase
  endfunction

  // State register; synchronous reset returns to FETCH from any state.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs; reset forces every output to zero.
  always_comb begin
    state_d          = S_FETCH;
    bus.IorD         = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemtoReg     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.PCSource     = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.RegDst       = 1'b0;
    bus.PCSel        = 1'b0;
    bus.ALUSrcB      = 2'b00;
    bus.ALUCtrl      = ALU_ADD;
    bus.done         = 1'b0;
    bus.illegal      = 1'b0;
    bus.state        = state_q;

    case (state_q)
      S_FETCH: begin
        // PC <= PC + 1 and IR <= mem[PC] in the same cycle.
        bus.MemRead = 1'b1;
        bus.IRWrite = 1'b1;
        bus.PCSel   = 1'b1;
        bus.ALUSrcB = 2'b01;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        bus.ALUSrcB = 2'b10;
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_RTYPE: begin
            if (funct_legal(bus.Function)) begin
              state_d = S_EXEC_R;
            end else begin
              bus.illegal = 1'b1;
              state_d     = S_FETCH;
            end
          end
          default: begin
            bus.illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        // IR is still stable here; lw and sw differ only in Op[3].
        state_d     = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = S_WB_MEM;
      end
      S_WB_MEM: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        bus.done     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        bus.done     = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUCtrl = funct_alu(bus.Function);
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        bus.done     = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        // Compare via subtract; PCSel follows Zero combinationally.
        bus.ALUSrcA  = 1'b1;
        bus.ALUCtrl  = ALU_SUB;
        bus.PCSource = 1'b1;
        bus.PCSel    = bus.Zero;
        bus.done     = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDI_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = S_WB_I;
      end
      S_WB_I: begin
        bus.RegWrite = 1'b1;
        bus.done     = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      bus.IorD     = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.PCSource = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.RegDst   = 1'b0;
      bus.PCSel    = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.ALUCtrl  = 4'b0000;
      bus.done     = 1'b0;
      bus.illegal  = 1'b0;
      bus.state    = 4'd0;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for the multi-cycle MIPS controller: directed instruction scenarios,
// a reset-mid-instruction scenario and a randomized instruction stream, each
// checked cycle by cycle against an instruction-level reference model.
module tb_mips_mc_control;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] exp_q[$];

  mips_mc_control_if bus ();

  mips_mc_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Observed control word, fixed field order for comparisons.
  function automatic logic [17:0] observed();
    return {bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.IRWrite,
            bus.PCSource, bus.ALUSrcA, bus.RegWrite, bus.RegDst, bus.PCSel,
            bus.ALUSrcB, bus.ALUCtrl, bus.done, bus.illegal};
  endfunction

  // Reference model: supported R-type function codes and their ALU ops.
  function automatic logic model_r_legal(input logic [5:0] f);
    logic [5:0] legal[6] = '{6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b101010, 6'b100111};
    foreach (legal[i]) if (legal[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_r_alu(input logic [5:0] f);
    logic [5:0] fc[6]  = '{6'b100000, 6'b100010, 6'b100100,
                           6'b100101, 6'b101010, 6'b100111};
    logic [3:0] alu[6] = '{4'b0010, 4'b0110, 4'b0000,
                           4'b0001, 4'b0111, 4'b1100};
    foreach (fc[i]) if (fc[i] == f) return alu[i];
    return 4'b0010;
  endfunction

  // Reference model: state sequence for one instruction, FETCH first.
  function automatic void model_path(input logic [5:0] op, input logic [5:0] fn);
    exp_q.delete();
    case (op)
      6'b100011: exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'b101011: exp_q = '{4'd0, 4'd1, 4'd2, 4'd5};
      6'b000100: exp_q = '{4'd0, 4'd1, 4'd8};
      6'b001000: exp_q = '{4'd0, 4'd1, 4'd9, 4'd10};
      6'b000000: if (model_r_legal(fn)) exp_q = '{4'd0, 4'd1, 4'd6, 4'd7};
                 else                   exp_q = '{4'd0, 4'd1};
      default:   exp_q = '{4'd0, 4'd1};
    endcase
  endfunction

  // Reference model: control word expected in a given step of an instruction.
  function automatic logic [17:0] model_ctrl(input logic [3:0] st, input logic [5:0] op,
                                             input logic [5:0] fn, input logic z);
    logic iord = 0, mr = 0, mw = 0, m2r = 0, irw = 0, pcs = 0, asa = 0;
    logic rw = 0, rd = 0, psel = 0, dn = 0, ill = 0;
    logic [1:0] asb = 2'b00;
    logic [3:0] alu = 4'b0010;
    case (st)
      4'd0:  begin mr = 1; irw = 1; psel = 1; asb = 2'b01; end
      4'd1:  begin asb = 2'b10; model_path(op, fn); ill = (exp_q.size() == 2); end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; dn = 1; end
      4'd5:  begin mw = 1; iord = 1; dn = 1; end
      4'd6:  begin asa = 1; alu = model_r_alu(fn); end
      4'd7:  begin rw = 1; rd = 1; dn = 1; end
      4'd8:  begin asa = 1; alu = 4'b0110; pcs = 1; psel = z; dn = 1; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {iord, mr, mw, m2r, irw, pcs, asa, rw, rd, psel, asb, alu, dn, ill};
  endfunction

  // Driver: runs one instruction from FETCH and checks every cycle of it.
  // Entered and left shortly after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [3:0]  path[$];
    logic [17:0] exp_w;
    model_path(op, fn);
    path = exp_q;
    bus.Op = op; bus.Function = fn; bus.Zero = z;
    #1;
    foreach (path[i]) begin
      checks++;
      if (bus.state !== path[i]) begin
        errors++;
        $display("FAIL state op=%b fn=%b step=%0d got=%0d want=%0d", op, fn, i, bus.state, path[i]);
      end
      exp_w = model_ctrl(path[i], op, fn, z);
      checks++;
      if (observed() !== exp_w) begin
        errors++;
        $display("FAIL ctrl op=%b fn=%b st=%0d got=%b want=%b", op, fn, path[i], observed(), exp_w);
      end
      checks++;
      if ((bus.MemWrite && bus.RegWrite) || (bus.IRWrite && bus.state != 4'd0) ||
          (bus.PCSel && bus.state != 4'd0 && bus.state != 4'd8)) begin
        errors++;
        $display("FAIL invariant st=%0d got=%b want=no_conflict", bus.state, observed());
      end
      if (path[i] == 4'd8) begin
        bus.Zero = ~z;
        #1;
        checks++;
        if (bus.PCSel !== ~z) begin
          errors++;
          $display("FAIL pcsel_zero got=%b want=%b", bus.PCSel, ~z);
        end
        bus.Zero = z;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("FAIL latency op=%b fn=%b got_state=%0d want=0 after %0d cycles", op, fn, bus.state, path.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.Op = 6'd0; bus.Function = 6'd0; bus.Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0 || observed() !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs state=%0d ctrl=%b want state=0 ctrl=0", bus.state, observed());
    end
    reset = 1'b0;
    #1;
    checks++;
    if (observed() !== model_ctrl(4'd0, 6'd0, 6'd0, 1'b0)) begin
      errors++;
      $display("FAIL reset_fetch got=%b want=%b", observed(), model_ctrl(4'd0, 6'd0, 6'd0, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    bus.Op = 6'b100011; bus.Function = 6'd0; bus.Zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.state !== 4'd3) begin
      errors++;
      $display("FAIL mid_memrd got=%0d want=3", bus.state);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== 18'd0) begin
      errors++;
      $display("FAIL reset_force got=%b want=0", observed());
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.state !== 4'd0 || observed() !== 18'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d state=%0d ctrl=%b want 0/0", c, bus.state, observed());
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (!(bus.MemRead === 1'b1 && bus.IRWrite === 1'b1 && bus.PCSel === 1'b1 && bus.state === 4'd0)) begin
      errors++;
      $display("FAIL reset_release got=%b state=%0d want MemRead/IRWrite/PCSel=1 state=0", observed(), bus.state);
    end
  endtask

  task automatic test_lw();    run_instr(6'b100011, 6'($urandom), 1'($urandom)); endtask
  task automatic test_sw();    run_instr(6'b101011, 6'($urandom), 1'($urandom)); endtask
  task automatic test_addi();  run_instr(6'b001000, 6'($urandom), 1'($urandom)); endtask

  task automatic test_rtype();
    run_instr(6'b000000, 6'b100010, 1'b0);
    run_instr(6'b000000, 6'b100111, 1'b1);
    run_instr(6'b000000, 6'b100000, 1'b0);
    run_instr(6'b000000, 6'b101010, 1'b0);
  endtask

  task automatic test_beq();
    run_instr(6'b000100, 6'd0, 1'b1);
    run_instr(6'b000100, 6'd0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr(6'b000000, 6'b001000, 1'b0);
    run_instr(6'b111111, 6'b100000, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[5] = '{6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000000};
    logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100,
                           6'b100101, 6'b101010, 6'b100111};
    logic [5:0] op;
    logic [5:0] fn;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: begin op = ops[$urandom_range(0, 3)]; fn = 6'($urandom); end
        3, 4:    begin op = ops[4]; fn = fns[$urandom_range(0, 5)]; end
        5:       begin op = 6'd0; fn = 6'($urandom); end
        default: begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      run_instr(op, fn, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_addi();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
